dac_sample_scheduler: RTL
=========================

Name: dac_sample_scheduler

Overview:
- Paces and arbitrates 12-bit audio samples from NUM_SRC producers into the single SPI DAC output controller.
- Produces a sample-rate tick from clock_50Mhz and grants one pending source per tick, round-robin.
- Drives the DAC controller's sendSample_n/inputSample pair and tracks its isBusy/transmitComplete handshake.
- Sits between the voice/synth sources and the SPI DAC controller at the top of the audio output path.

Parameters:
NUM_SRC, 4, number of sample producers (2..8)
SAMPLE_W, 12, sample width in bits
TICK_DIV, 2268, clock_50Mhz cycles per sample tick (50 MHz / 22050 Hz)
BUSY_TIMEOUT, 255, cycles allowed in REQ for synchronized dac_isBusy to rise

Ports:
clock_50Mhz  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = tick counter runs; 0 = counter held at 0, no new grants
src_sample  in  NUM_SRC*SAMPLE_W  packed samples; source i occupies bits [i*12 +: 12]
src_valid  in  NUM_SRC  source i offers a sample
src_ready  out  NUM_SRC  source i's hold register is empty
dac_inputSample  out  12  sample presented to the DAC controller
dac_sendSample_n  out  1  active-low send request to the DAC controller
dac_isBusy  in  1  DAC controller busy (asynchronous to this block's timing; synchronize)
dac_transmitComplete  in  1  DAC controller done level (asynchronous; synchronize)
active_src  out  3  index of the last granted source
underrun  out  1  1-cycle pulse: tick arrived with no source pending
overrun  out  1  1-cycle pulse: tick arrived while the previous transfer was unfinished
timeout_err  out  1  1-cycle pulse: isBusy did not rise within BUSY_TIMEOUT

Behaviour:
- Reset values:
  - src_ready = all 1s; all hold registers empty.
  - dac_sendSample_n = 1; dac_inputSample = 0; active_src = 0.
  - Pulse outputs = 0; tick counter = 0; state = IDLE.
  - Round-robin pointer = NUM_SRC-1, so source 0 wins first.
- Hold registers:
  - src_valid[i] & src_ready[i] loads the hold register on that edge; src_ready[i] is 0 on the next cycle.
  - The register is cleared when granted.
  - Grant and a new load for the same source may occur in the same cycle; the new load wins and src_ready stays 0.
- Tick:
  - The counter counts 0..TICK_DIV-1 while enable = 1.
  - tick = 1 for exactly one cycle when the counter equals TICK_DIV-1, then the counter wraps to 0.
  - Deasserting enable clears the counter but lets an in-flight transfer finish.
- Synchronizers: dac_isBusy and dac_transmitComplete pass through 2-flop synchronizers. busy_s and done_s denote the synchronized signals; done_rise is the rising-edge detect of done_s.
- FSM:
  - IDLE:
    - On tick with any hold register full: grant the next full source after the pointer (round-robin), latch its sample into dac_inputSample, set active_src, update the pointer, and go to REQ.
    - On tick with none full: pulse underrun and stay in IDLE.
  - REQ:
    - dac_sendSample_n = 0 and a timeout counter runs.
    - When busy_s = 1, raise sendSample_n and go to WAIT.
    - If the counter reaches BUSY_TIMEOUT first, raise sendSample_n, pulse timeout_err, and go to IDLE; the sample is discarded.
  - WAIT:
    - On done_rise, or busy_s falling, go to IDLE.
    - dac_inputSample is held stable from grant until the FSM leaves WAIT.
- Overrun:
  - A tick in REQ or WAIT pulses overrun and is dropped (no queuing).
  - Hold registers keep their contents.
- Simultaneous events: a tick in the same cycle as the return to IDLE counts as an overrun; it does not also start a grant.
- Reset mid-transfer: all state returns to reset values immediately and dac_sendSample_n = 1 asynchronously. The DAC controller's own reset handles its side.

Decomposition:
- Package dac_sched_pkg: state enum {IDLE, REQ, WAIT}, SAMPLE_W, localparam DAC_TICK_DIV_22K = 2268.
- Sub-module rr_arbiter (NUM_SRC): inputs req vector and pointer; outputs one-hot grant and grant index; purely combinational.
- Synchronizers and tick counter stay inline.

Test Plan:
- Single source: TICK_DIV = 64, source 0 offers 12'hABC once, DAC model (busy 5 cycles after send, done 20 cycles later) -> dac_inputSample = 12'hABC, sendSample_n low until busy_s, active_src = 0, src_ready[0] returns to 1 after grant.
- Round-robin: all 4 sources hold samples 12'h001..12'h004 -> grants in order 0,1,2,3 on four consecutive ticks; pointer wraps so a refilled source 0 is granted on the fifth tick.
- Underrun: no valid sources for 3 ticks -> three 1-cycle underrun pulses; dac_sendSample_n stays 1.
- Overrun: DAC model holds busy for 100 cycles with TICK_DIV = 64 -> overrun pulses on the tick during WAIT, no second grant until done_rise; the pending sample is granted on the following tick.
- Timeout: DAC model never asserts isBusy -> sendSample_n low for BUSY_TIMEOUT cycles, then 1; timeout_err pulses once; FSM returns to IDLE and the next tick grants the next source.
- Reset mid-REQ: assert reset_n = 0 while sendSample_n = 0 -> sendSample_n = 1 immediately, src_ready all 1s, counter 0; normal operation resumes after release.

Source files
------------

// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler.
package dac_sched_pkg;

    localparam int unsigned SAMPLE_W         = 12;
    localparam int unsigned DAC_TICK_DIV_22K = 2268;  // 50 MHz / 22050 Hz
    localparam int unsigned SRC_IDX_W        = 3;     // enough for up to 8 sources

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } sched_state_e;

endpackage

// File: rtl/dac_sample_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after ptr_i.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]   req_i,
    input  logic [SRC_IDX_W-1:0] ptr_i,
    output logic [NUM_SRC-1:0]   gnt_o,
    output logic [SRC_IDX_W-1:0] gnt_idx_o,
    output logic                 gnt_valid_o
);

    int unsigned rank;
    int unsigned best;

    // Rank each requester by its distance after the pointer; lowest rank wins.
    always_comb begin
        gnt_idx_o = '0;
        gnt_o     = '0;
        rank      = 0;
        best      = NUM_SRC;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rank = (i + 2 * NUM_SRC - 32'(ptr_i) - 1) % NUM_SRC;
            if (req_i[i] && (rank < best)) begin
                best      = rank;
                gnt_idx_o = SRC_IDX_W'(i);
            end
        end
        gnt_valid_o = (best < NUM_SRC);
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            gnt_o[i] = gnt_valid_o && (gnt_idx_o == SRC_IDX_W'(i));
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Paces samples from NUM_SRC producers into the SPI DAC controller, one grant per tick.
module dac_sample_scheduler #(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned SAMPLE_W     = dac_sched_pkg::SAMPLE_W,
    parameter int unsigned TICK_DIV     = dac_sched_pkg::DAC_TICK_DIV_22K,
    parameter int unsigned BUSY_TIMEOUT = 255
) (
    input  logic                         clock_50Mhz,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [NUM_SRC*SAMPLE_W-1:0]  src_sample,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    output logic [SAMPLE_W-1:0]          dac_inputSample,
    output logic                         dac_sendSample_n,
    input  logic                         dac_isBusy,
    input  logic                         dac_transmitComplete,
    output logic [2:0]                   active_src,
    output logic                         underrun,
    output logic                         overrun,
    output logic                         timeout_err
);

    import dac_sched_pkg::*;

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned ToW  = $clog2(BUSY_TIMEOUT + 1);

    logic                 busy_meta_q, busy_s_q, done_meta_q, done_s_q, done_prev_q;
    logic                 done_rise;
    logic [CntW-1:0]      cnt_q;
    logic                 tick;
    logic [SAMPLE_W-1:0]  hold_q [NUM_SRC];
    logic [SAMPLE_W-1:0]  hold_d [NUM_SRC];
    logic [NUM_SRC-1:0]   full_q, full_d, load;
    sched_state_e         state_q, state_d;
    logic [SRC_IDX_W-1:0] ptr_q, ptr_d, active_q, active_d;
    logic [SAMPLE_W-1:0]  sample_q, sample_d;
    logic [ToW-1:0]       to_cnt_q, to_cnt_d;
    logic                 underrun_q, underrun_d, overrun_q, overrun_d, timeout_q, timeout_d;
    logic [NUM_SRC-1:0]   gnt;
    logic [SRC_IDX_W-1:0] gnt_idx;
    logic                 gnt_valid;
    logic                 grant;

    rr_arbiter #(
        .NUM_SRC(NUM_SRC)
    ) u_arb (
        .req_i      (full_q),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .gnt_idx_o  (gnt_idx),
        .gnt_valid_o(gnt_valid)
    );

    assign done_rise        = done_s_q & ~done_prev_q;
    assign tick             = enable && (cnt_q == CntW'(TICK_DIV - 1));
    assign grant            = (state_q == StIdle) && tick && gnt_valid;
    assign src_ready        = ~full_q;
    assign dac_inputSample  = sample_q;
    assign dac_sendSample_n = (state_q != StReq);
    assign active_src       = active_q;
    assign underrun         = underrun_q;
    assign overrun          = overrun_q;
    assign timeout_err      = timeout_q;

    // Two-flop synchronizers for the DAC handshake, plus edge history for done.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            busy_meta_q <= dac_isBusy;
            busy_s_q    <= busy_meta_q;
            done_meta_q <= dac_transmitComplete;
            done_s_q    <= done_meta_q;
            done_prev_q <= done_s_q;
        end
    end

    // Sample-rate divider; held at zero while disabled.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (!enable || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // Hold registers: a grant empties the slot, a new load in the same cycle wins.
    always_comb begin
        load   = src_valid & ~full_q;
        full_d = full_q;
        hold_d = hold_q;
        if (grant) begin
            full_d = full_q & ~gnt;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (load[i]) begin
                full_d[i] = 1'b1;
                hold_d[i] = src_sample[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Hold register state.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            full_q <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            full_q <= full_d;
            hold_q <= hold_d;
        end
    end

    // Transfer FSM next-state: grant on tick, request until busy, wait until done.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        sample_d   = sample_q;
        to_cnt_d   = to_cnt_q;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    if (gnt_valid) begin
                        for (int unsigned i = 0; i < NUM_SRC; i++) begin
                            if (gnt[i]) begin
                                sample_d = hold_q[i];
                            end
                        end
                        active_d = gnt_idx;
                        ptr_d    = gnt_idx;
                        to_cnt_d = '0;
                        state_d  = StReq;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
            end
            StReq: begin
                overrun_d = tick;
                if (busy_s_q) begin
                    state_d = StWait;
                end else if (to_cnt_q == ToW'(BUSY_TIMEOUT - 1)) begin
                    // DAC never acknowledged: drop the sample.
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            StWait: begin
                overrun_d = tick;
                if (done_rise || !busy_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            ptr_q      <= SRC_IDX_W'(NUM_SRC - 1);
            active_q   <= '0;
            sample_q   <= '0;
            to_cnt_q   <= '0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            active_q   <= active_d;
            sample_q   <= sample_d;
            to_cnt_q   <= to_cnt_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
